// File: rtl/noc_traffic_gen_if.sv
// Flit bus between a traffic generator and a destination FIFO.
// The generator drives dataOut/write; the FIFO returns its full/almost_full status.
interface noc_traffic_gen_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] dataOut;
  logic              write;
  logic              full;
  logic              almost_full;

  modport master (output dataOut, output write, input full, input almost_full);
  modport slave  (input dataOut, input write, output full, output almost_full);
endinterface

// File: rtl/noc_traffic_gen.sv
// NoC traffic generator: issues {seq, id, dest, 1} flits in fixed, round-robin or LFSR-random destination modes.
// Latency: one flit per cycle at most; write and all status outputs are registered, one cycle after the decision.
// Backpressure: full (no write last cycle) or almost_full (write last cycle) stalls issue and counts a stall cycle.
module noc_traffic_gen #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 2,
  parameter int CNT_W  = DATA_W - 2*ID_W - 1
) (
  input  logic                clk,
  input  logic                reset,
  noc_traffic_gen_if.master   bus,
  input  logic [ID_W-1:0]     id,
  input  logic [ID_W-1:0]     to,
  input  logic [1:0]          mode,
  input  logic                enable,
  input  logic                start,
  input  logic [15:0]         budget,
  input  logic [3:0]          gap,
  output logic                busy,
  output logic                done,
  output logic [15:0]         sent_count,
  output logic [15:0]         stall_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  logic [1:0]       state;
  logic [CNT_W-1:0] seq;
  logic [15:0]      budget_q;
  logic [3:0]       gap_q;
  logic [3:0]       gap_cnt;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_next;
  // Round-robin pointer kept as an offset from id so it never lands on id itself.
  logic [ID_W-1:0]  rr_off;
  logic [ID_W-1:0]  rr_off_inc;
  logic [ID_W-1:0]  rr_off_next;
  logic [ID_W-1:0]  id_next;
  logic [ID_W-1:0]  rr_dest;
  logic [ID_W-1:0]  rnd_dest;
  logic [ID_W-1:0]  dest;
  logic [15:0]      sent_inc;
  logic             blocked;
  logic             issue;
  logic             last_pkt;

  assign id_next     = id + ID_W'(1);
  assign rr_dest     = id + rr_off;
  assign rr_off_inc  = rr_off + ID_W'(1);
  assign rr_off_next = (rr_off_inc == '0) ? ID_W'(1) : rr_off_inc;
  assign lfsr_next   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign rnd_dest    = (lfsr[ID_W-1:0] == id) ? id_next : lfsr[ID_W-1:0];

  always_comb begin
    dest = to;
    case (mode)
      2'b01:   dest = rr_dest;
      2'b10:   dest = rnd_dest;
      default: dest = to;
    endcase
  end

  // A write issued last cycle consumes the last free slot when almost_full is set.
  assign blocked  = (bus.write & bus.almost_full) | (~bus.write & bus.full);
  assign issue    = (state == SEND) & enable & ~blocked & ~start;
  assign sent_inc = sent_count + 16'd1;
  assign last_pkt = (budget_q != 16'd0) && (sent_inc == budget_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bus.dataOut <= '0;
      bus.write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_count  <= '0;
      stall_count <= '0;
      seq         <= '0;
      budget_q    <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      lfsr        <= LFSR_SEED;
      rr_off      <= ID_W'(1);
    end else if (start) begin
      state       <= SEND;
      bus.write   <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      sent_count  <= '0;
      stall_count <= '0;
      seq         <= '0;
      budget_q    <= budget;
      gap_q       <= gap;
      gap_cnt     <= '0;
      lfsr        <= LFSR_SEED;
      rr_off      <= ID_W'(1);
    end else begin
      bus.write <= issue;
      if (enable) begin
        case (state)
          SEND: begin
            if (issue) begin
              bus.dataOut <= {seq, id, dest, 1'b1};
              seq         <= seq + CNT_W'(1);
              sent_count  <= sent_inc;
              if (mode == 2'b10) lfsr   <= lfsr_next;
              if (mode == 2'b01) rr_off <= rr_off_next;
              if (last_pkt) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (gap_q != 4'd0) begin
                state   <= GAP;
                gap_cnt <= gap_q;
              end
            end else if (stall_count != 16'hFFFF) begin
              stall_count <= stall_count + 16'd1;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt - 4'd1;
            if (gap_cnt <= 4'd1) state <= SEND;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
